// File: rtl/dtw_job_sched.sv
// dtw_job_sched: command queue, job launcher and source/sink stream glue for dtw_core.
module dtw_job_sched #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned START_TMO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [31:0]       cmd_len,
  input  logic              cmd_mode,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              core_start,
  output logic [31:0]       core_ref_len,
  output logic              core_op_mode,
  input  logic              core_running,
  input  logic              core_src_rden,
  output logic              core_src_empty,
  output logic [31:0]       core_src_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              core_sink_wren,
  output logic              core_sink_full,
  input  logic [31:0]       core_sink_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic              done_err,
  output logic [31:0]       done_words
);

  localparam int unsigned QAW   = $clog2(QDEPTH);
  localparam int unsigned PW    = QAW + 1;
  localparam int unsigned TMO_W = $clog2(START_TMO + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [31:0]       len;
    logic              mode;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RUN, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  cmd_t             q_mem [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             q_full, q_empty, push, pop;
  cmd_t             job;
  logic [TMO_W-1:0] tmo;
  logic             tmo_hit;
  logic             err;
  logic [31:0]      srv;
  logic [31:0]      words;
  logic             src_acc, sink_load, sink_drop;

  assign q_empty   = (wr_ptr == rd_ptr);
  assign q_full    = (wr_ptr[QAW] != rd_ptr[QAW]) && (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
  assign cmd_ready = !q_full;
  assign push      = cmd_valid && !q_full;
  assign pop       = (state == IDLE) && !q_empty;

  // Command queue storage
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr[QAW-1:0]] <= '{base: cmd_base, len: cmd_len, mode: cmd_mode, tag: cmd_tag};
  end

  // Command queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Job registers, served/word counters and error flag, all restarted at pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job   <= '0;
      srv   <= '0;
      words <= '0;
      err   <= 1'b0;
    end else if (pop) begin
      job   <= q_mem[rd_ptr[QAW-1:0]];
      srv   <= '0;
      words <= '0;
      err   <= 1'b0;
    end else begin
      if (src_acc)   srv   <= srv + 32'd1;
      if (sink_load) words <= words + 32'd1;
      if (sink_drop || (state == WAIT_RUN && !core_running && tmo_hit)) err <= 1'b1;
    end
  end

  // Start timeout counter, cleared in LAUNCH and counting through WAIT_RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmo <= '0;
    else if (state == LAUNCH)   tmo <= '0;
    else if (state == WAIT_RUN) tmo <= tmo + TMO_W'(1);
  end

  assign tmo_hit = (tmo == TMO_W'(START_TMO - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!q_empty) state_n = LAUNCH;
      LAUNCH:   state_n = WAIT_RUN;
      WAIT_RUN: if (core_running) state_n = RUN;
                else if (tmo_hit) state_n = DONE;
      RUN:      if (!core_running) state_n = DRAIN;
      DRAIN:    if (!res_valid) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    core_start = 1'b0;
    done_valid = 1'b0;
    case (state)
      LAUNCH:  core_start = 1'b1;
      DONE:    done_valid = 1'b1;
      default: ;
    endcase
  end

  assign done_tag     = done_valid ? job.tag : '0;
  assign done_err     = done_valid && err;
  assign done_words   = done_valid ? words : '0;
  assign core_ref_len = job.len;
  assign core_op_mode = job.mode;

  // Source feed: serve reads from reference memory until len samples are out
  assign core_src_empty = !(state == WAIT_RUN || state == RUN) || (srv == job.len);
  assign src_acc        = core_src_rden && !core_src_empty;
  assign mem_rd_en      = src_acc;
  assign mem_addr       = src_acc ? (job.base + srv[ADDR_W-1:0]) : '0;
  assign core_src_data  = {16'h0000, mem_rdata};

  // Sink path handshake
  assign core_sink_full = res_valid && !res_ready;
  assign sink_load      = core_sink_wren && !core_sink_full;
  assign sink_drop      = core_sink_wren && core_sink_full;

  // One-entry result holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else if (sink_load) begin
      res_valid <= 1'b1;
      res_data  <= core_sink_data;
      res_tag   <= job.tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtw_job_sched.sv
// Directed bench for dtw_job_sched with a simple core and memory model.
module tb_dtw_job_sched;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [31:0]       cmd_len;
  logic              cmd_mode;
  logic [TAG_W-1:0]  cmd_tag;
  logic              core_start, core_op_mode, core_running;
  logic [31:0]       core_ref_len;
  logic              core_src_rden, core_src_empty;
  logic [31:0]       core_src_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              core_sink_wren, core_sink_full;
  logic [31:0]       core_sink_data;
  logic              res_valid, res_ready;
  logic [31:0]       res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              done_valid, done_err;
  logic [TAG_W-1:0]  done_tag;
  logic [31:0]       done_words;

  dtw_job_sched dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .core_start(core_start), .core_ref_len(core_ref_len), .core_op_mode(core_op_mode),
    .core_running(core_running),
    .core_src_rden(core_src_rden), .core_src_empty(core_src_empty), .core_src_data(core_src_data),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_sink_wren(core_sink_wren), .core_sink_full(core_sink_full), .core_sink_data(core_sink_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err), .done_words(done_words)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a);
    return {1'b0, a} ^ 16'h5A3C;
  endfunction

  // Reference memory model, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= pat(mem_addr);
  end

  // Monitor state written only by the monitor process
  int                rd_cnt = 0, addr_bad = 0, data_bad = 0, start_cnt = 0, done_cnt = 0;
  logic              prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0]       rq_data[$];
  logic [TAG_W-1:0]  rq_tag[$];
  // Written only by the main sequence
  logic [ADDR_W-1:0] exp_base = '0;
  int                rd_mark = 0;

  // Observe reads, returned data, start/done pulses and delivered results
  always @(negedge clk) begin
    if (rst) begin
      prev_rd <= 1'b0;
    end else begin
      if (prev_rd && (core_src_data !== {16'h0000, pat(prev_addr)})) data_bad <= data_bad + 1;
      prev_rd   <= mem_rd_en;
      prev_addr <= mem_addr;
      if (mem_rd_en) begin
        if (mem_addr !== ADDR_W'(int'(exp_base) + rd_cnt - rd_mark)) addr_bad <= addr_bad + 1;
        rd_cnt <= rd_cnt + 1;
      end
      if (core_start) start_cnt <= start_cnt + 1;
      if (done_valid) done_cnt <= done_cnt + 1;
      if (res_valid && res_ready) begin
        rq_data.push_back(res_data);
        rq_tag.push_back(res_tag);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] b, input logic [31:0] l, input logic m,
                      input logic [TAG_W-1:0] t);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_base = b; cmd_len = l; cmd_mode = m; cmd_tag = t;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
      tick();
    end
    tick();
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  // Returns at the negedge of the LAUNCH cycle
  task automatic wait_start();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (core_start) begin ok = 1; break; end
      tick();
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output logic [TAG_W-1:0] t, output logic e, output logic [31:0] w);
    bit ok = 0;
    t = '0; e = 1'b0; w = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_valid) begin ok = 1; t = done_tag; e = done_err; w = done_words; break; end
      tick();
    end
    tick();
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  // Core model: nrd blind reads, then nwr sink writes honouring full; res_ready low for stall cycles
  task automatic core_run(input int nrd, input int nwr, input int stall, input logic [31:0] wbase,
                          output bit saw_full);
    int wrote = 0;
    int c = 0;
    saw_full = 0;
    core_running = 1'b1;
    for (int i = 0; i < nrd; i++) begin
      core_src_rden = 1'b1;
      tick();
    end
    core_src_rden = 1'b0;
    while ((wrote < nwr || c < stall) && c < 500) begin
      res_ready = (c >= stall);
      #1;
      if (core_sink_full) saw_full = 1;
      if (wrote < nwr && !core_sink_full) begin
        core_sink_wren = 1'b1;
        core_sink_data = wbase + 32'(wrote);
        wrote++;
      end else begin
        core_sink_wren = 1'b0;
      end
      tick();
      c++;
    end
    core_sink_wren = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();
    core_running = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({pfx, "_core_start"}, 32'(core_start), 32'd0);
    chk({pfx, "_ref_len"}, core_ref_len, 32'd0);
    chk({pfx, "_op_mode"}, 32'(core_op_mode), 32'd0);
    chk({pfx, "_src_empty"}, 32'(core_src_empty), 32'd1);
    chk({pfx, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({pfx, "_sink_full"}, 32'(core_sink_full), 32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_done_valid"}, 32'(done_valid), 32'd0);
    chk({pfx, "_done_tag"}, 32'(done_tag), 32'd0);
    chk({pfx, "_done_err"}, 32'(done_err), 32'd0);
    chk({pfx, "_done_words"}, done_words, 32'd0);
  endtask

  initial begin
    logic [TAG_W-1:0] dt;
    logic             de;
    logic [31:0]      dw;
    bit               sf;
    int               rm, sc, dc, rd0, k;

    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_mode = 1'b0; cmd_tag = '0;
    core_running = 1'b0; core_src_rden = 1'b0; core_sink_wren = 1'b0; core_sink_data = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Job 1: base 0x0100, len 250, mode 1, tag 3, with latency check
    exp_base = 15'h0100; rd_mark = rd_cnt; sc = start_cnt; dc = done_cnt; rm = rq_data.size();
    cmd_valid = 1'b1; cmd_base = 15'h0100; cmd_len = 32'd250; cmd_mode = 1'b1; cmd_tag = 4'd3;
    @(negedge clk);
    chk("j1_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("j1_start_at_n1", 32'(core_start), 32'd0);
    tick();
    @(negedge clk);
    chk("j1_start_at_n2", 32'(core_start), 32'd1);
    chk("j1_ref_len", core_ref_len, 32'd250);
    chk("j1_op_mode", 32'(core_op_mode), 32'd1);
    tick();
    core_run(250, 4, 0, 32'hC0DE0000, sf);
    wait_done(dt, de, dw);
    chk("j1_done_tag", 32'(dt), 32'd3);
    chk("j1_done_err", 32'(de), 32'd0);
    chk("j1_done_words", dw, 32'd4);
    chk("j1_reads", 32'(rd_cnt - rd_mark), 32'd250);
    chk("j1_addr_bad", 32'(addr_bad), 32'd0);
    chk("j1_data_bad", 32'(data_bad), 32'd0);
    chk("j1_start_pulses", 32'(start_cnt - sc), 32'd1);
    chk("j1_done_pulses", 32'(done_cnt - dc), 32'd1);
    chk("j1_res_count", 32'(rq_data.size() - rm), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rm + i < rq_data.size()) begin
        chk("j1_res_data", rq_data[rm + i], 32'hC0DE0000 + 32'(i));
        chk("j1_res_tag", 32'(rq_tag[rm + i]), 32'd3);
      end
    end

    // Job 2: over-read, 260 reads against len 250
    exp_base = 15'h0200; rd_mark = rd_cnt;
    push(15'h0200, 32'd250, 1'b0, 4'd5);
    wait_start();
    chk("j2_op_mode", 32'(core_op_mode), 32'd0);
    tick();
    core_running = 1'b1;
    for (int i = 0; i < 260; i++) begin
      core_src_rden = 1'b1;
      tick();
    end
    core_src_rden = 1'b0;
    @(negedge clk);
    chk("j2_empty_after_len", 32'(core_src_empty), 32'd1);
    chk("j2_reads", 32'(rd_cnt - rd_mark), 32'd250);
    tick();
    core_run(0, 1, 0, 32'h22220000, sf);
    wait_done(dt, de, dw);
    chk("j2_done_tag", 32'(dt), 32'd5);
    chk("j2_done_words", dw, 32'd1);
    chk("j2_addr_bad", 32'(addr_bad), 32'd0);

    // Job 3: address wrap from 0x7FF0
    exp_base = 15'h7FF0; rd_mark = rd_cnt;
    push(15'h7FF0, 32'd32, 1'b0, 4'd6);
    wait_start();
    tick();
    core_run(32, 0, 0, 32'h0, sf);
    wait_done(dt, de, dw);
    chk("j3_reads", 32'(rd_cnt - rd_mark), 32'd32);
    chk("j3_addr_bad", 32'(addr_bad), 32'd0);
    chk("j3_data_bad", 32'(data_bad), 32'd0);
    chk("j3_done_tag", 32'(dt), 32'd6);
    chk("j3_done_err", 32'(de), 32'd0);

    // Job 4: res_ready low for 20 cycles while 3 words are written
    exp_base = 15'h0000; rd_mark = rd_cnt; rm = rq_data.size();
    push(15'h0000, 32'd4, 1'b1, 4'd7);
    wait_start();
    tick();
    core_run(4, 3, 20, 32'hA0000000, sf);
    wait_done(dt, de, dw);
    chk("j4_saw_full", 32'(sf), 32'd1);
    chk("j4_res_count", 32'(rq_data.size() - rm), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (rm + i < rq_data.size()) begin
        chk("j4_res_data", rq_data[rm + i], 32'hA0000000 + 32'(i));
        chk("j4_res_tag", 32'(rq_tag[rm + i]), 32'd7);
      end
    end
    chk("j4_done_err", 32'(de), 32'd0);
    chk("j4_done_words", dw, 32'd3);

    // Job 5 times out, job 6 queued behind it launches after the minimum gap
    exp_base = 15'h0040; rd_mark = rd_cnt;
    push(15'h0010, 32'd8, 1'b0, 4'd9);
    push(15'h0040, 32'd8, 1'b1, 4'd10);
    wait_start();
    tick();
    k = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_valid) begin k = i; break; end
      tick();
    end
    chk("j5_tmo_cycles", 32'(k), 32'd64);
    chk("j5_done_tag", 32'(done_tag), 32'd9);
    chk("j5_done_err", 32'(done_err), 32'd1);
    chk("j5_done_words", done_words, 32'd0);
    tick();
    @(negedge clk);
    chk("j6_start_gap1", 32'(core_start), 32'd0);
    tick();
    @(negedge clk);
    chk("j6_start_gap2", 32'(core_start), 32'd1);
    chk("j6_ref_len", core_ref_len, 32'd8);
    tick();
    core_run(8, 1, 0, 32'h66660000, sf);
    wait_done(dt, de, dw);
    chk("j6_done_tag", 32'(dt), 32'd10);
    chk("j6_done_err", 32'(de), 32'd0);
    chk("j6_reads", 32'(rd_cnt - rd_mark), 32'd8);

    // Queue fills while a job runs, then reset mid-RUN drops everything
    push(15'h0000, 32'd16, 1'b1, 4'd1);
    wait_start();
    tick();
    core_running = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_tag = TAG_W'(i + 2);
      @(negedge clk);
      chk("q_ready_free", 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_valid = 1'b1; cmd_tag = 4'd6;
    @(negedge clk);
    chk("q_ready_full", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("q_ready_still_full", 32'(cmd_ready), 32'd0);
    tick();
    core_src_rden = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    cmd_valid = 1'b0; core_src_rden = 1'b0; core_running = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sc = start_cnt; dc = done_cnt; rd0 = rd_cnt;
    repeat (20) tick();
    chk("post_rst_no_start", 32'(start_cnt - sc), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - dc), 32'd0);
    chk("post_rst_no_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
